// File: rtl/enc_bhl.sv
// ---------------------------------------------------------------------------
// enc_bhl : 8-to-3 priority encoder with optional output register.
//
// Turns eight request lines D0..D7 into a 3-bit index {x,y,z} (x = MSB).
// When several lines are high, the highest index wins. valid separates
// "D0 alone" (code 000, valid=1) from idle (code 000, valid=0).
//
// Parameters:
//   REG_OUT  1 = outputs registered, one cycle of latency (default)
//            0 = outputs follow D0..D7 combinationally
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset, clears all outputs
//   en       in   register update enable (0 = hold)
//   D0..D7   in   request lines, index 0..7
//   x,y,z    out  encoded index, x = bit 2, z = bit 0
//   valid    out  at least one request line was high
//   err      out  two or more request lines were high
//                 (present only when ENC_ERR_FLAG_EN is defined)
//
// Build option: define ENC_ERR_FLAG_EN to add the err port and its logic.
// ---------------------------------------------------------------------------
module enc_bhl #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    output logic x,
    output logic y,
    output logic z,
`ifdef ENC_ERR_FLAG_EN
    output logic err,
`endif
    output logic valid
);

    logic [7:0] d_vec;
    logic [2:0] code_d;
    logic       valid_d;

    assign d_vec = {D7, D6, D5, D4, D3, D2, D1, D0};

    // Ascending scan: later (higher) indices overwrite lower ones, which
    // gives highest-index priority for multi-hot inputs.
    always_comb begin
        code_d = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (d_vec[k]) code_d = 3'(k);
        end
    end

    assign valid_d = |d_vec;

`ifdef ENC_ERR_FLAG_EN
    logic err_d;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign err_d = |(d_vec & (d_vec - 8'd1));
`endif

    generate
        if (REG_OUT) begin : g_reg
            logic [2:0] code_q;
            logic       valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_q  <= 3'd0;
                    valid_q <= 1'b0;
                end else if (en) begin
                    code_q  <= code_d;
                    valid_q <= valid_d;
                end
            end

            assign {x, y, z} = code_q;
            assign valid     = valid_q;

`ifdef ENC_ERR_FLAG_EN
            logic err_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  err_q <= 1'b0;
                else if (en) err_q <= err_d;
            end
            assign err = err_q;
`endif
        end else begin : g_comb
            assign {x, y, z} = code_d;
            assign valid     = valid_d;
`ifdef ENC_ERR_FLAG_EN
            assign err       = err_d;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_enc_bhl.sv
// ---------------------------------------------------------------------------
// tb_enc_bhl : bench for enc_bhl in its default registered mode.
// Table-driven vectors, hand-written reset/hold sequences and a random run
// against a behavioural model. err is checked when ENC_ERR_FLAG_EN is set.
// ---------------------------------------------------------------------------
module tb_enc_bhl;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [7:0] d;
    logic x, y, z, valid;
`ifdef ENC_ERR_FLAG_EN
    logic err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc_bhl #(.REG_OUT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .D0    (d[0]),
        .D1    (d[1]),
        .D2    (d[2]),
        .D3    (d[3]),
        .D4    (d[4]),
        .D5    (d[5]),
        .D6    (d[6]),
        .D7    (d[7]),
        .x     (x),
        .y     (y),
        .z     (z),
`ifdef ENC_ERR_FLAG_EN
        .err   (err),
`endif
        .valid (valid)
    );

    // Reference: index of the highest set bit, count of set bits.
    function automatic logic [2:0] ref_code(input logic [7:0] v);
        int hi;
        hi = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                hi = i;
                break;
            end
        end
        return 3'(hi);
    endfunction

    function automatic logic ref_err(input logic [7:0] v);
        return $countones(v) >= 2;
    endfunction

    task automatic chk(input string name, input logic [2:0] exp_code,
                       input logic exp_vld, input logic exp_err);
        checks++;
        if ({x, y, z} !== exp_code || valid !== exp_vld) begin
            failures++;
            $display("FAIL %s: got code=%b valid=%b, expected code=%b valid=%b",
                     name, {x, y, z}, valid, exp_code, exp_vld);
        end
`ifdef ENC_ERR_FLAG_EN
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s: got err=%b, expected err=%b", name, err, exp_err);
        end
`else
        if (exp_err === 1'bx) $display("unexpected x");
`endif
    endtask

    // Drive on the falling edge, sample 1ns after the next rising edge.
    task automatic cyc(input logic [7:0] dv, input logic env);
        @(negedge clk);
        d  = dv;
        en = env;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       en;
        logic [2:0] code;
        logic       vld;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] dv, input logic e,
                                input logic [2:0] c, input logic v, input logic er);
        vec_t t;
        t.d = dv; t.en = e; t.code = c; t.vld = v; t.err = er;
        return t;
    endfunction

    logic [2:0] m_code;
    logic       m_vld;
    logic       m_err;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 8'h80;

        // Reset held with D7 high and clock running: outputs stay cleared.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 3'b000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", 3'b111, 1'b1, 1'b0);

        // Vector table: one-hot sweep, idle vs D0, multi-hot, enable hold.
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(8'(1 << k), 1'b1, 3'(k), 1'b1, 1'b0));
        tbl.push_back(mk(8'h00, 1'b1, 3'b000, 1'b0, 1'b0));
        tbl.push_back(mk(8'h01, 1'b1, 3'b000, 1'b1, 1'b0));
        tbl.push_back(mk(8'h24, 1'b1, 3'b101, 1'b1, 1'b1));
        tbl.push_back(mk(8'h8A, 1'b1, 3'b111, 1'b1, 1'b1));
        tbl.push_back(mk(8'h40, 1'b1, 3'b110, 1'b1, 1'b0));
        tbl.push_back(mk(8'h02, 1'b0, 3'b110, 1'b1, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 3'b110, 1'b1, 1'b0));
        tbl.push_back(mk(8'h02, 1'b1, 3'b001, 1'b1, 1'b0));
        tbl.push_back(mk(8'hFF, 1'b1, 3'b111, 1'b1, 1'b1));

        foreach (tbl[i]) begin
            cyc(tbl[i].d, tbl[i].en);
            chk($sformatf("vec%0d", i), tbl[i].code, tbl[i].vld, tbl[i].err);
        end

        // Async reset between edges clears the outputs before any edge.
        cyc(8'h20, 1'b1);
        chk("pre_async", 3'b101, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 3'b000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        // The release lands mid-cycle, so the next edge captures.
        @(posedge clk);
        #1;
        chk("post_async", 3'b101, 1'b1, 1'b0);

        // Random stream against the model; en randomly dropped.
        m_code = 3'b101;
        m_vld  = 1'b1;
        m_err  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rd;
            logic       re;
            rd = 8'($urandom);
            if ($urandom_range(3) == 0) rd = 8'(1 << $urandom_range(7));
            if ($urandom_range(7) == 0) rd = 8'h00;
            re = ($urandom_range(3) != 0);
            cyc(rd, re);
            if (re) begin
                m_code = ref_code(rd);
                m_vld  = (rd != 8'h00);
                m_err  = ref_err(rd);
            end
            chk($sformatf("rand%0d", i), m_code, m_vld, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against any hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
